fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end: PC register, single-outstanding instruction-memory request interface, and IF/ID output register.
- Consumes the pipeline control outputs: jump redirect plus hold flag.
- On jump it redirects the PC and squashes in-flight fetches. On hold it freezes the PC and emits bubbles to decode.
- Sits between the controller and instruction memory on one side and the decode stage on the other.

Parameters:
- RESET_ADDR, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven to decode.
- HOLD_W, 3, width of hold flag; any nonzero value means hold.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- jumpFlagIn  in  1  redirect request, 1 = jump
- jumpAddrIn  in  32  redirect target, valid when jumpFlagIn=1
- holdFlagIn  in  HOLD_W  pipeline hold; nonzero = hold
- imemReqOut  out  1  instruction memory request
- imemAddrOut  out  32  request address
- imemAckIn  in  1  request accepted, data valid this cycle
- imemDataIn  in  32  instruction word, valid with imemAckIn
- instOut  out  32  IF/ID instruction
- instAddrOut  out  32  IF/ID instruction address
- instValidOut  out  1  IF/ID contents are a real instruction
- pcOut  out  32  next fetch PC (debug/trace)

Behaviour:
- Reset (rst=1 at clock edge, any state, including mid-request):
  - state=IDLE, pc=RESET_ADDR, pending target cleared.
  - imemReqOut=0, imemAddrOut=RESET_ADDR.
  - instOut=NOP_INST, instAddrOut=0, instValidOut=0.
  - An in-flight request is abandoned; an ack arriving after reset is ignored unless the unit is in FETCH.
- IDLE: go to FETCH next cycle; imemAddrOut loads pc.
- Protocol rule: once imemReqOut=1, imemAddrOut stays constant until the cycle imemAckIn=1. One outstanding request max. Ack is only sampled while imemReqOut=1.
- FETCH (imemReqOut=1):
  - ack, jump: data dropped; pc=jumpAddrIn; IF/ID=bubble. Next state is HOLD_WAIT if holdFlagIn nonzero after this cycle's evaluation, else FETCH with imemAddrOut=jumpAddrIn.
  - ack, no jump, hold: data dropped; pc unchanged; IF/ID=bubble; go to HOLD_WAIT.
  - ack, no jump, no hold: IF/ID loads instOut=imemDataIn, instAddrOut=imemAddrOut, instValidOut=1 (1-cycle latency from ack). pc=pc+4 (mod 2^32, wraps FFFF_FFFC->0). imemAddrOut=pc+4; stay FETCH back-to-back.
  - no ack, jump: pending target=jumpAddrIn; go to DISCARD; imemAddrOut held.
  - no ack, no jump: IF/ID=bubble; imemAddrOut held.
- DISCARD (imemReqOut=1, old address):
  - A new jump overwrites the pending target (last wins).
  - On ack: data dropped; pc=pending target (or jumpAddrIn if jump this cycle). Go to HOLD_WAIT if hold, else FETCH with imemAddrOut=pc.
  - IF/ID=bubble throughout.
- HOLD_WAIT (imemReqOut=0):
  - IF/ID=bubble.
  - A jump updates pc.
  - When holdFlagIn==0 and jumpFlagIn==0: go to FETCH, imemAddrOut=pc.
- Bubble means instOut=NOP_INST, instValidOut=0, instAddrOut unchanged.
- Jump and hold together: jump wins for pc; hold decides whether a request issues next cycle.
- jumpAddrIn is used unmodified; no alignment check.
- pcOut = pc register.

Optional Feature:
- FETCH_SKID_EN defined:
  - Ack with hold and no jump stores data and address in a 1-entry skid buffer, and pc advances by 4.
  - On hold release, the buffered instruction goes to IF/ID with valid=1 in the first non-hold cycle. No memory request that cycle; FETCH follows with imemAddrOut=pc.
  - Any jump or rst invalidates the buffer.
- FETCH_SKID_EN undefined: held data is dropped and the same pc is refetched after release.

Test Plan:
- rst=1 for 3 cycles then 0 -> imemReqOut=0 and instOut=0x00000013 and instValidOut=0 during reset. One cycle later imemReqOut=1, imemAddrOut=0x0.
- Ack every cycle with data 0x00100093, 0x00200113, 0x00300193 -> instAddrOut 0x0, 0x4, 0x8 with instValidOut=1, each one cycle after its ack. Addresses are back-to-back.
- Jump to 0x100 in the same cycle as the ack for 0x8 -> that data is dropped and instValidOut=0. Next imemAddrOut=0x100, or HOLD_WAIT until hold clears.
- Jump to 0x200 while the request for 0x8 is pending and ack is delayed 3 cycles -> imemAddrOut stays 0x8 until ack, data dropped, then request 0x200 issues.
- Hold nonzero for 4 cycles, acked at 0x10:
  - Skid off -> bubbles, imemReqOut=0, then request 0x10.
  - Skid on -> bubbles, then instOut=word@0x10 with valid=1, then request 0x14.
- rst asserted in DISCARD with pending target 0x300 -> next cycle IDLE. First request is RESET_ADDR; 0x300 is never fetched.
- pc=0xFFFF_FFFC acked -> next request 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, single-outstanding imem request, IF/ID register.
// Optional 1-entry skid buffer for data acked under hold: define FETCH_SKID_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter logic [31:0] NOP_INST   = 32'h0000_0013,
   parameter int          HOLD_W     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jumpFlagIn,
   input  logic [31:0]       jumpAddrIn,
   input  logic [HOLD_W-1:0] holdFlagIn,
   output logic              imemReqOut,
   output logic [31:0]       imemAddrOut,
   input  logic              imemAckIn,
   input  logic [31:0]       imemDataIn,
   output logic [31:0]       instOut,
   output logic [31:0]       instAddrOut,
   output logic              instValidOut,
   output logic [31:0]       pcOut,
   output logic [1:0]        stateOut
);

   // Handshake: imemReqOut=1 holds imemAddrOut stable until the cycle imemAckIn=1,
   // which both accepts the request and carries imemDataIn; ack is ignored while
   // imemReqOut=0, and at most one request is ever outstanding.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FETCH     = 2'd1,
      DISCARD   = 2'd2,
      HOLD_WAIT = 2'd3
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pend;
   logic        hold;
   logic [31:0] pc_inc;
   logic [31:0] redirect;

`ifdef FETCH_SKID_EN
   logic        skid_valid;
   logic [31:0] skid_inst;
   logic [31:0] skid_addr;
`endif

   assign hold     = |holdFlagIn;
   assign pc_inc   = pc + 32'd4;
   // A jump arriving in DISCARD overrides the previously pending target.
   assign redirect = jumpFlagIn ? jumpAddrIn : pend;
   assign pcOut    = pc;
   assign stateOut = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         pc           <= RESET_ADDR;
         pend         <= 32'd0;
         imemReqOut   <= 1'b0;
         imemAddrOut  <= RESET_ADDR;
         instOut      <= NOP_INST;
         instAddrOut  <= 32'd0;
         instValidOut <= 1'b0;
`ifdef FETCH_SKID_EN
         skid_valid   <= 1'b0;
         skid_inst    <= NOP_INST;
         skid_addr    <= 32'd0;
`endif
      end else begin
         instOut      <= NOP_INST;
         instValidOut <= 1'b0;
`ifdef FETCH_SKID_EN
         if (jumpFlagIn) skid_valid <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               state       <= FETCH;
               imemReqOut  <= 1'b1;
               imemAddrOut <= pc;
            end
            FETCH: begin
               if (imemAckIn) begin
                  if (jumpFlagIn) begin
                     pc <= jumpAddrIn;
                     if (hold) begin
                        state      <= HOLD_WAIT;
                        imemReqOut <= 1'b0;
                     end else begin
                        imemAddrOut <= jumpAddrIn;
                     end
                  end else if (hold) begin
                     state      <= HOLD_WAIT;
                     imemReqOut <= 1'b0;
`ifdef FETCH_SKID_EN
                     skid_valid <= 1'b1;
                     skid_inst  <= imemDataIn;
                     skid_addr  <= imemAddrOut;
                     pc         <= pc_inc;
`endif
                  end else begin
                     instOut      <= imemDataIn;
                     instAddrOut  <= imemAddrOut;
                     instValidOut <= 1'b1;
                     pc           <= pc_inc;
                     imemAddrOut  <= pc_inc;
                  end
               end else if (jumpFlagIn) begin
                  pend  <= jumpAddrIn;
                  state <= DISCARD;
               end
            end
            DISCARD: begin
               if (jumpFlagIn) pend <= jumpAddrIn;
               if (imemAckIn) begin
                  pc <= redirect;
                  if (hold) begin
                     state      <= HOLD_WAIT;
                     imemReqOut <= 1'b0;
                  end else begin
                     state       <= FETCH;
                     imemAddrOut <= redirect;
                  end
               end
            end
            HOLD_WAIT: begin
               if (jumpFlagIn) begin
                  pc <= jumpAddrIn;
               end else if (!hold) begin
                  state       <= FETCH;
                  imemReqOut  <= 1'b1;
                  imemAddrOut <= pc;
`ifdef FETCH_SKID_EN
                  if (skid_valid) begin
                     instOut      <= skid_inst;
                     instAddrOut  <= skid_addr;
                     instValidOut <= 1'b1;
                     skid_valid   <= 1'b0;
                  end
`endif
               end
            end
            default: begin
               state      <= IDLE;
               imemReqOut <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// against a transaction-level reference model (honours FETCH_SKID_EN).
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        jumpFlagIn;
   logic [31:0] jumpAddrIn;
   logic [2:0]  holdFlagIn;
   logic        imemReqOut;
   logic [31:0] imemAddrOut;
   logic        imemAckIn;
   logic [31:0] imemDataIn;
   logic [31:0] instOut;
   logic [31:0] instAddrOut;
   logic        instValidOut;
   logic [31:0] pcOut;
   logic [1:0]  dbg_state;

   int checks   = 0;
   int failures = 0;

   fetch_unit dut (
      .clk(clk), .rst(rst),
      .jumpFlagIn(jumpFlagIn), .jumpAddrIn(jumpAddrIn), .holdFlagIn(holdFlagIn),
      .imemReqOut(imemReqOut), .imemAddrOut(imemAddrOut),
      .imemAckIn(imemAckIn), .imemDataIn(imemDataIn),
      .instOut(instOut), .instAddrOut(instAddrOut), .instValidOut(instValidOut),
      .pcOut(pcOut), .stateOut(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Tracks the outstanding request, whether its data will be thrown away,
   // and whether fetching is parked waiting for hold to drop.
   logic [31:0] m_pc, m_addr, m_target, m_out_inst, m_out_addr, m_sk_inst, m_sk_addr;
   bit          m_busy, m_squash, m_boot, m_parked, m_out_valid, m_sk_valid;
   logic [63:0] exp_q[$];

   task automatic model_step(input logic r, input logic j, input logic [31:0] ja,
                             input logic [2:0] h, input logic a, input logic [31:0] d);
      bit hold;
      hold = (h != 3'd0);
      m_out_valid = 1'b0;
      m_out_inst  = NOP;
      if (r) begin
         m_pc = 32'd0; m_addr = 32'd0; m_target = 32'd0; m_out_addr = 32'd0;
         m_busy = 1'b0; m_squash = 1'b0; m_boot = 1'b1; m_parked = 1'b0;
         m_sk_valid = 1'b0;
         return;
      end
      if (j) m_sk_valid = 1'b0;
      if (m_boot) begin
         m_boot = 1'b0; m_busy = 1'b1; m_addr = m_pc;
      end else if (m_busy && a) begin
         if (!m_squash && !j && !hold) begin
            m_out_valid = 1'b1; m_out_inst = d; m_out_addr = m_addr;
            exp_q.push_back({m_addr, d});
            m_pc = m_pc + 32'd4; m_addr = m_pc;
         end else if (!m_squash && !j) begin
            m_busy = 1'b0; m_parked = 1'b1;
`ifdef FETCH_SKID_EN
            m_sk_valid = 1'b1; m_sk_inst = d; m_sk_addr = m_addr;
            m_pc = m_pc + 32'd4;
`endif
         end else begin
            m_pc = j ? ja : m_target;
            m_squash = 1'b0;
            if (hold) begin m_busy = 1'b0; m_parked = 1'b1; end
            else m_addr = m_pc;
         end
      end else if (m_busy) begin
         if (j) begin m_squash = 1'b1; m_target = ja; end
      end else if (m_parked) begin
         if (j) m_pc = ja;
         else if (!hold) begin
            m_parked = 1'b0; m_busy = 1'b1; m_addr = m_pc;
            if (m_sk_valid) begin
               m_out_valid = 1'b1; m_out_inst = m_sk_inst; m_out_addr = m_sk_addr;
               exp_q.push_back({m_sk_addr, m_sk_inst});
               m_sk_valid = 1'b0;
            end
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle(input logic r, input logic j, input logic [31:0] ja,
                        input logic [2:0] h, input logic a, input logic [31:0] d);
      rst = r; jumpFlagIn = j; jumpAddrIn = ja; holdFlagIn = h;
      imemAckIn = a; imemDataIn = d;
      model_step(r, j, ja, h, a, d);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0);
      cycle(1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0);
   endtask

   task automatic ack_seq(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 3'd0, 1'b1, $urandom);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, 32'd0, 3'd0, 1'b1, 32'hdead_beef);
         checks++;
         if (imemReqOut !== 1'b0 || instOut !== NOP || instValidOut !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got req=%b inst=%h valid=%b exp req=0 inst=%h valid=0",
                     imemReqOut, instOut, instValidOut, NOP);
         end
      end
      checks++;
      if (imemAddrOut !== 32'd0 || instAddrOut !== 32'd0 || pcOut !== 32'd0) begin
         failures++;
         $display("FAIL reset_addrs got addr=%h iaddr=%h pc=%h exp all 0",
                  imemAddrOut, instAddrOut, pcOut);
      end
      cycle(1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0);
      checks++;
      if (imemReqOut !== 1'b1 || imemAddrOut !== 32'd0) begin
         failures++;
         $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", imemReqOut, imemAddrOut);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] words [3];
      words[0] = 32'h0010_0093; words[1] = 32'h0020_0113; words[2] = 32'h0030_0193;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 32'd0, 3'd0, 1'b1, words[i]);
         checks++;
         if (instValidOut !== 1'b1 || instOut !== words[i] || instAddrOut !== 32'(4 * i)
             || imemReqOut !== 1'b1 || imemAddrOut !== 32'(4 * (i + 1))) begin
            failures++;
            $display("FAIL seq_%0d got v=%b inst=%h iaddr=%h req=%b addr=%h exp v=1 inst=%h iaddr=%h req=1 addr=%h",
                     i, instValidOut, instOut, instAddrOut, imemReqOut, imemAddrOut,
                     words[i], 32'(4 * i), 32'(4 * (i + 1)));
         end
      end
   endtask

   task automatic test_jump_on_ack();
      do_reset();
      ack_seq(2);
      cycle(1'b0, 1'b1, 32'h100, 3'd0, 1'b1, 32'h0030_0193);
      checks++;
      if (instValidOut !== 1'b0 || instOut !== NOP || imemReqOut !== 1'b1
          || imemAddrOut !== 32'h100 || pcOut !== 32'h100) begin
         failures++;
         $display("FAIL jump_ack got v=%b inst=%h req=%b addr=%h pc=%h exp v=0 inst=%h req=1 addr=100 pc=100",
                  instValidOut, instOut, imemReqOut, imemAddrOut, pcOut, NOP);
      end
      do_reset();
      ack_seq(2);
      cycle(1'b0, 1'b1, 32'h100, 3'd3, 1'b1, 32'h0030_0193);
      cycle(1'b0, 1'b0, 32'd0, 3'd1, 1'b0, 32'd0);
      checks++;
      if (imemReqOut !== 1'b0 || instValidOut !== 1'b0 || pcOut !== 32'h100) begin
         failures++;
         $display("FAIL jump_hold_wait got req=%b v=%b pc=%h exp req=0 v=0 pc=100",
                  imemReqOut, instValidOut, pcOut);
      end
      cycle(1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0);
      checks++;
      if (imemReqOut !== 1'b1 || imemAddrOut !== 32'h100) begin
         failures++;
         $display("FAIL jump_hold_release got req=%b addr=%h exp req=1 addr=100", imemReqOut, imemAddrOut);
      end
   endtask

   task automatic test_discard();
      do_reset();
      ack_seq(2);
      cycle(1'b0, 1'b1, 32'h200, 3'd0, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (imemReqOut !== 1'b1 || imemAddrOut !== 32'h8 || instValidOut !== 1'b0) begin
            failures++;
            $display("FAIL discard_hold_addr_%0d got req=%b addr=%h v=%b exp req=1 addr=8 v=0",
                     i, imemReqOut, imemAddrOut, instValidOut);
         end
         cycle(1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0);
      end
      cycle(1'b0, 1'b0, 32'd0, 3'd0, 1'b1, 32'h0030_0193);
      checks++;
      if (instValidOut !== 1'b0 || imemReqOut !== 1'b1 || imemAddrOut !== 32'h200) begin
         failures++;
         $display("FAIL discard_redirect got v=%b req=%b addr=%h exp v=0 req=1 addr=200",
                  instValidOut, imemReqOut, imemAddrOut);
      end
      cycle(1'b0, 1'b0, 32'd0, 3'd0, 1'b1, 32'h1234_5678);
      checks++;
      if (instValidOut !== 1'b1 || instAddrOut !== 32'h200 || instOut !== 32'h1234_5678) begin
         failures++;
         $display("FAIL discard_first_inst got v=%b iaddr=%h inst=%h exp v=1 iaddr=200 inst=12345678",
                  instValidOut, instAddrOut, instOut);
      end
   endtask

   task automatic test_hold();
      logic [31:0] word;
      logic [2:0]  h;
      word = $urandom;
      do_reset();
      ack_seq(4);
      for (int i = 0; i < 4; i++) begin
         h = 3'($urandom_range(1, 7));
         cycle(1'b0, 1'b0, 32'd0, h, (i == 0), word);
         checks++;
         if (imemReqOut !== 1'b0 || instValidOut !== 1'b0 || instOut !== NOP) begin
            failures++;
            $display("FAIL hold_bubble_%0d got req=%b v=%b inst=%h exp req=0 v=0 inst=%h",
                     i, imemReqOut, instValidOut, instOut, NOP);
         end
      end
      cycle(1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0);
`ifdef FETCH_SKID_EN
      checks++;
      if (instValidOut !== 1'b1 || instOut !== word || instAddrOut !== 32'h10
          || imemReqOut !== 1'b1 || imemAddrOut !== 32'h14) begin
         failures++;
         $display("FAIL hold_release_skid got v=%b inst=%h iaddr=%h req=%b addr=%h exp v=1 inst=%h iaddr=10 req=1 addr=14",
                  instValidOut, instOut, instAddrOut, imemReqOut, imemAddrOut, word);
      end
`else
      checks++;
      if (instValidOut !== 1'b0 || imemReqOut !== 1'b1 || imemAddrOut !== 32'h10) begin
         failures++;
         $display("FAIL hold_release_refetch got v=%b req=%b addr=%h exp v=0 req=1 addr=10",
                  instValidOut, imemReqOut, imemAddrOut);
      end
`endif
   endtask

   task automatic test_reset_in_discard();
      do_reset();
      ack_seq(1);
      cycle(1'b0, 1'b1, 32'h300, 3'd0, 1'b0, 32'd0);
      cycle(1'b1, 1'b0, 32'd0, 3'd0, 1'b1, 32'hcafe_f00d);
      checks++;
      if (imemReqOut !== 1'b0 || instValidOut !== 1'b0 || instAddrOut !== 32'd0 || pcOut !== 32'd0) begin
         failures++;
         $display("FAIL rst_discard got req=%b v=%b iaddr=%h pc=%h exp req=0 v=0 iaddr=0 pc=0",
                  imemReqOut, instValidOut, instAddrOut, pcOut);
      end
      cycle(1'b0, 1'b0, 32'd0, 3'd0, 1'b1, 32'hcafe_f00d);
      checks++;
      if (imemReqOut !== 1'b1 || imemAddrOut !== 32'd0 || instValidOut !== 1'b0) begin
         failures++;
         $display("FAIL rst_discard_refetch got req=%b addr=%h v=%b exp req=1 addr=0 v=0",
                  imemReqOut, imemAddrOut, instValidOut);
      end
      cycle(1'b0, 1'b0, 32'd0, 3'd0, 1'b1, 32'h0000_0093);
      checks++;
      if (instAddrOut !== 32'd0 || instValidOut !== 1'b1 || imemAddrOut !== 32'h4) begin
         failures++;
         $display("FAIL rst_discard_no_target got iaddr=%h v=%b addr=%h exp iaddr=0 v=1 addr=4",
                  instAddrOut, instValidOut, imemAddrOut);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 3'd0, 1'b1, 32'd0);
      cycle(1'b0, 1'b0, 32'd0, 3'd0, 1'b1, 32'h0000_0013);
      checks++;
      if (instValidOut !== 1'b1 || instAddrOut !== 32'hFFFF_FFFC || imemAddrOut !== 32'd0 || pcOut !== 32'd0) begin
         failures++;
         $display("FAIL pc_wrap got v=%b iaddr=%h addr=%h pc=%h exp v=1 iaddr=fffffffc addr=0 pc=0",
                  instValidOut, instAddrOut, imemAddrOut, pcOut);
      end
   endtask

   task automatic test_random();
      logic        r, j, a;
      logic [31:0] ja, d;
      logic [2:0]  h;
      logic [63:0] exp_item;
      do_reset();
      exp_q.delete();
      for (int n = 0; n < 3000; n++) begin
         r  = ($urandom_range(0, 199) == 0);
         j  = ($urandom_range(0, 7) == 0);
         ja = $urandom;
         h  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         a  = ($urandom_range(0, 2) != 0);
         d  = $urandom;
         cycle(r, j, ja, h, a, d);
         checks++;
         if (imemReqOut !== m_busy || (m_busy && imemAddrOut !== m_addr) || pcOut !== m_pc) begin
            failures++;
            $display("FAIL rand_req cyc=%0d got req=%b addr=%h pc=%h exp req=%b addr=%h pc=%h",
                     n, imemReqOut, imemAddrOut, pcOut, m_busy, m_addr, m_pc);
         end
         checks++;
         if (instValidOut !== m_out_valid || instOut !== m_out_inst || instAddrOut !== m_out_addr) begin
            failures++;
            $display("FAIL rand_ifid cyc=%0d got v=%b inst=%h iaddr=%h exp v=%b inst=%h iaddr=%h",
                     n, instValidOut, instOut, instAddrOut, m_out_valid, m_out_inst, m_out_addr);
         end
         if (instValidOut === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL rand_scoreboard cyc=%0d got iaddr=%h inst=%h exp nothing delivered",
                        n, instAddrOut, instOut);
            end else begin
               exp_item = exp_q.pop_front();
               if ({instAddrOut, instOut} !== exp_item) begin
                  failures++;
                  $display("FAIL rand_scoreboard cyc=%0d got %h exp %h", n, {instAddrOut, instOut}, exp_item);
               end
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL rand_undelivered got %0d left exp 0", exp_q.size());
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1; jumpFlagIn = 1'b0; jumpAddrIn = 32'd0; holdFlagIn = 3'd0;
      imemAckIn = 1'b0; imemDataIn = 32'd0;
      @(negedge clk);
      test_reset();
      test_sequential();
      test_jump_on_ack();
      test_discard();
      test_hold();
      test_reset_in_discard();
      test_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
